// File: rtl/int_commit_stage.sv
// Integer commit stage: retires in-order ROB head entries through a one-entry
// output register to the integer RF write port. Optional macro INT_COMMIT_INSTRET_EN adds a 64-bit retire counter.
module int_commit_stage #(
   parameter int unsigned ROB_IDX_LEN = 4,
   parameter int unsigned EXCEPT_LEN  = 6,
   parameter int unsigned REG_IDX_LEN = 5,
   parameter int unsigned XLEN        = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   rob_valid_i,
   output logic                   rob_ready_o,
   input  logic [ROB_IDX_LEN-1:0] rob_idx_i,
   input  logic                   rob_has_rd_i,
   input  logic [REG_IDX_LEN-1:0] rob_rd_idx_i,
   input  logic [XLEN-1:0]        rob_value_i,
   input  logic                   rob_except_i,
   input  logic [EXCEPT_LEN-1:0]  rob_except_code_i,
   output logic                   rf_valid_o,
   input  logic                   rf_ready_i,
   output logic [REG_IDX_LEN-1:0] rf_rd_idx_o,
   output logic [XLEN-1:0]        rf_rd_value_o,
   output logic                   rs_clr_valid_o,
   output logic [REG_IDX_LEN-1:0] rs_clr_rd_idx_o,
   output logic [ROB_IDX_LEN-1:0] rs_clr_rob_idx_o,
   output logic                   flush_o,
   output logic                   except_valid_o,
   output logic [EXCEPT_LEN-1:0]  except_code_o
`ifdef INT_COMMIT_INSTRET_EN
   ,
   output logic [63:0]            instret_o
`endif
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t                 state;
   logic                   out_valid;
   logic [REG_IDX_LEN-1:0] out_rd;
   logic [XLEN-1:0]        out_value;
   logic [ROB_IDX_LEN-1:0] out_rob_idx;

   logic drain;
   logic accept;
   logic load;

   // An exception waits for an empty or draining output register, so older
   // writes always leave before the flush.
   assign drain       = out_valid && rf_ready_i;
   assign rob_ready_o = (state == ST_RUN) && (!out_valid || drain);
   assign accept      = rob_valid_i && rob_ready_o;
   assign load        = accept && !rob_except_i && rob_has_rd_i &&
                        (rob_rd_idx_i != REG_IDX_LEN'(0));

   assign rf_valid_o       = out_valid;
   assign rf_rd_idx_o      = out_rd;
   assign rf_rd_value_o    = out_value;
   assign rs_clr_valid_o   = drain;
   assign rs_clr_rd_idx_o  = out_rd;
   assign rs_clr_rob_idx_o = out_rob_idx;

   // Control FSM, output register and exception pulse registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= ST_RUN;
         out_valid      <= 1'b0;
         out_rd         <= '0;
         out_value      <= '0;
         out_rob_idx    <= '0;
         flush_o        <= 1'b0;
         except_valid_o <= 1'b0;
         except_code_o  <= '0;
      end else begin
         flush_o        <= 1'b0;
         except_valid_o <= 1'b0;
         case (state)
            ST_RUN: begin
               if (accept && rob_except_i) begin
                  state          <= ST_FLUSH;
                  flush_o        <= 1'b1;
                  except_valid_o <= 1'b1;
                  except_code_o  <= rob_except_code_i;
               end
            end
            ST_FLUSH: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase

         // Drain and reload share one edge so back-to-back retires have no bubble.
         if (load) begin
            out_valid   <= 1'b1;
            out_rd      <= rob_rd_idx_i;
            out_value   <= rob_value_i;
            out_rob_idx <= rob_idx_i;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef INT_COMMIT_INSTRET_EN
   // Retired-instruction counter; exceptions do not count, wraps at 2^64.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         instret_o <= '0;
      end else if (accept && !rob_except_i) begin
         instret_o <= instret_o + 64'(1);
      end
   end
`endif

endmodule

// File: tb/tb_int_commit_stage.sv
// Self-checking bench for int_commit_stage: per-cycle vector table plus
// hand-written reset sequences.
module tb_int_commit_stage;

   logic        clk;
   logic        rst_n;
   logic        rob_valid;
   logic        rob_ready;
   logic [3:0]  rob_idx;
   logic        rob_has_rd;
   logic [4:0]  rob_rd_idx;
   logic [31:0] rob_value;
   logic        rob_except;
   logic [5:0]  rob_except_code;
   logic        rf_valid;
   logic        rf_ready;
   logic [4:0]  rf_rd_idx;
   logic [31:0] rf_rd_value;
   logic        rs_clr_valid;
   logic [4:0]  rs_clr_rd_idx;
   logic [3:0]  rs_clr_rob_idx;
   logic        flush;
   logic        except_valid;
   logic [5:0]  except_code;
`ifdef INT_COMMIT_INSTRET_EN
   logic [63:0] instret;
`endif

   int errors = 0;
   int checks = 0;

   int_commit_stage dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .rob_valid_i       (rob_valid),
      .rob_ready_o       (rob_ready),
      .rob_idx_i         (rob_idx),
      .rob_has_rd_i      (rob_has_rd),
      .rob_rd_idx_i      (rob_rd_idx),
      .rob_value_i       (rob_value),
      .rob_except_i      (rob_except),
      .rob_except_code_i (rob_except_code),
      .rf_valid_o        (rf_valid),
      .rf_ready_i        (rf_ready),
      .rf_rd_idx_o       (rf_rd_idx),
      .rf_rd_value_o     (rf_rd_value),
      .rs_clr_valid_o    (rs_clr_valid),
      .rs_clr_rd_idx_o   (rs_clr_rd_idx),
      .rs_clr_rob_idx_o  (rs_clr_rob_idx),
      .flush_o           (flush),
      .except_valid_o    (except_valid),
      .except_code_o     (except_code)
`ifdef INT_COMMIT_INSTRET_EN
      ,
      .instret_o         (instret)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [3:0]  idx;
      logic        hrd;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        exc;
      logic [5:0]  code;
      logic        rdy;
      logic        e_rr;
      logic        e_rfv;
      logic [4:0]  e_rd;
      logic [31:0] e_val;
      logic        e_clr;
      logic [3:0]  e_crob;
      logic        e_fl;
      logic        e_exv;
      logic [5:0]  e_code;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input int v, input int idx, input int hrd, input int rd,
                               input int val, input int exc, input int code, input int rdy,
                               input int e_rr, input int e_rfv, input int e_rd, input int e_val,
                               input int e_clr, input int e_crob, input int e_fl,
                               input int e_exv, input int e_code);
      vec_t r;
      r.v = 1'(v);        r.idx = 4'(idx);     r.hrd = 1'(hrd);     r.rd = 5'(rd);
      r.val = 32'(val);   r.exc = 1'(exc);     r.code = 6'(code);   r.rdy = 1'(rdy);
      r.e_rr = 1'(e_rr);  r.e_rfv = 1'(e_rfv); r.e_rd = 5'(e_rd);   r.e_val = 32'(e_val);
      r.e_clr = 1'(e_clr); r.e_crob = 4'(e_crob); r.e_fl = 1'(e_fl);
      r.e_exv = 1'(e_exv); r.e_code = 6'(e_code);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t r);
      rob_valid       = r.v;
      rob_idx         = r.idx;
      rob_has_rd      = r.hrd;
      rob_rd_idx      = r.rd;
      rob_value       = r.val;
      rob_except      = r.exc;
      rob_except_code = r.code;
      rf_ready        = r.rdy;
   endtask

   logic [63:0] exp_instret;

   initial begin
      // single entry, then 8 back-to-back retires
      vecs[0] = mk(1, 1, 1, 5, 'hDEAD, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 1,       1, 1, 5, 'hDEAD, 1, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++)
         vecs[1+i] = mk(1, i+1, 1, i, 'h1000+i, 0, 0, 1,
                        1, int'(i > 1), i-1, 'h1000+i-1, int'(i > 1), i, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 8, 'h1008, 1, 9, 0, 0, 0);
      // three-cycle RF stall, then drain and accept on the same edge
      vecs[11] = mk(1, 10, 1, 3, 'h33, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 11, 1, 4, 'h44, 0, 0, 0,  0, 1, 3, 'h33, 0, 0, 0, 0, 0);
      vecs[13] = vecs[12];
      vecs[14] = vecs[12];
      vecs[15] = mk(1, 11, 1, 4, 'h44, 0, 0, 1,  1, 1, 3, 'h33, 1, 10, 0, 0, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 4, 'h44, 1, 11, 0, 0, 0);
      // rd = x0 and no-rd entries retire silently
      vecs[17] = mk(1, 12, 1, 0, 'h55, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[18] = mk(1, 13, 0, 7, 'h66, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0, 0, 0, 0, 0);
      // exception behind a stalled write
      vecs[20] = mk(1, 14, 1, 3, 'h77, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[21] = mk(1, 15, 1, 9, 'h99, 1, 2, 0,  0, 1, 3, 'h77, 0, 0, 0, 0, 0);
      vecs[22] = vecs[21];
      vecs[23] = mk(1, 15, 1, 9, 'h99, 1, 2, 1,  1, 1, 3, 'h77, 1, 14, 0, 0, 0);
      vecs[24] = mk(1, 0, 1, 6, 'h88, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 2);
      vecs[25] = mk(1, 0, 1, 6, 'h88, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 6, 'h88, 1, 0, 0, 0, 0);
      vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0, 0, 0, 0, 0);

      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      chk("reset rf_valid", 64'(rf_valid), 64'(0));
      chk("reset rf_rd_idx", 64'(rf_rd_idx), 64'(0));
      chk("reset rf_rd_value", 64'(rf_rd_value), 64'(0));
      chk("reset rs_clr_valid", 64'(rs_clr_valid), 64'(0));
      chk("reset flush", 64'(flush), 64'(0));
      chk("reset except_valid", 64'(except_valid), 64'(0));
      chk("reset except_code", 64'(except_code), 64'(0));
`ifdef INT_COMMIT_INSTRET_EN
      chk("reset instret", instret, 64'(0));
`endif
      step();
      step();
      rst_n = 1'b1;
      #2;
      chk("post-reset rob_ready", 64'(rob_ready), 64'(1));
      step();

      exp_instret = '0;
      for (int n = 0; n < NV; n++) begin
         drive(vecs[n]);
         #3;
         chk($sformatf("v%0d rob_ready", n), 64'(rob_ready), 64'(vecs[n].e_rr));
         chk($sformatf("v%0d rf_valid", n), 64'(rf_valid), 64'(vecs[n].e_rfv));
         chk($sformatf("v%0d rs_clr_valid", n), 64'(rs_clr_valid), 64'(vecs[n].e_clr));
         chk($sformatf("v%0d flush", n), 64'(flush), 64'(vecs[n].e_fl));
         chk($sformatf("v%0d except_valid", n), 64'(except_valid), 64'(vecs[n].e_exv));
         if (vecs[n].e_rfv) begin
            chk($sformatf("v%0d rf_rd_idx", n), 64'(rf_rd_idx), 64'(vecs[n].e_rd));
            chk($sformatf("v%0d rf_rd_value", n), 64'(rf_rd_value), 64'(vecs[n].e_val));
         end
         if (vecs[n].e_clr) begin
            chk($sformatf("v%0d rs_clr_rd_idx", n), 64'(rs_clr_rd_idx), 64'(vecs[n].e_rd));
            chk($sformatf("v%0d rs_clr_rob_idx", n), 64'(rs_clr_rob_idx), 64'(vecs[n].e_crob));
         end
         if (vecs[n].e_exv)
            chk($sformatf("v%0d except_code", n), 64'(except_code), 64'(vecs[n].e_code));
`ifdef INT_COMMIT_INSTRET_EN
         chk($sformatf("v%0d instret", n), instret, exp_instret);
         if (vecs[n].v && vecs[n].e_rr && !vecs[n].exc)
            exp_instret = exp_instret + 64'(1);
`endif
         step();
      end

      // asynchronous reset while a write is pending
      drive(mk(1, 3, 1, 10, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      rob_valid = 1'b0;
      #1;
      chk("pending rf_valid", 64'(rf_valid), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async rst rf_valid", 64'(rf_valid), 64'(0));
      chk("async rst rf_rd_idx", 64'(rf_rd_idx), 64'(0));
      chk("async rst rf_rd_value", 64'(rf_rd_value), 64'(0));
      chk("async rst rs_clr_valid", 64'(rs_clr_valid), 64'(0));
      step();
      rst_n = 1'b1;
      rf_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         chk($sformatf("after rst%0d rf_valid", k), 64'(rf_valid), 64'(0));
         chk($sformatf("after rst%0d rs_clr_valid", k), 64'(rs_clr_valid), 64'(0));
         step();
      end

      // asynchronous reset during FLUSH
      drive(mk(1, 4, 1, 2, 'hBB, 1, 'h2A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      chk("exc rob_ready", 64'(rob_ready), 64'(1));
      step();
      rob_valid  = 1'b0;
      rob_except = 1'b0;
      #1;
      chk("flush pulse", 64'(flush), 64'(1));
      chk("flush except_valid", 64'(except_valid), 64'(1));
      chk("flush except_code", 64'(except_code), 64'('h2A));
      chk("flush rob_ready", 64'(rob_ready), 64'(0));
      chk("flush rf_valid", 64'(rf_valid), 64'(0));
      #1;
      rst_n = 1'b0;
      #1;
      chk("flush rst flush", 64'(flush), 64'(0));
      chk("flush rst except_valid", 64'(except_valid), 64'(0));
      chk("flush rst except_code", 64'(except_code), 64'(0));
`ifdef INT_COMMIT_INSTRET_EN
      chk("flush rst instret", instret, 64'(0));
`endif
      step();
      rst_n = 1'b1;
      #3;
      chk("resume rob_ready", 64'(rob_ready), 64'(1));
      chk("resume flush", 64'(flush), 64'(0));
      chk("resume rf_valid", 64'(rf_valid), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/int_commit_stage.md
# int_commit_stage

Integer commit stage. Takes completed instructions in order from the head of the reorder buffer and retires them through a one-entry output register. Destination results are sent to the integer register file write port through a valid/ready handshake. It also clears matching register-status entries and raises a one-cycle flush on exceptions.

## Interface
- `ROB_IDX_LEN`, default 4: width of ROB entry index/tag.
- `EXCEPT_LEN`, default 6: width of exception code.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `rob_valid_i` in 1: ROB head entry valid and complete.
- `rob_ready_o` out 1: stage accepts head entry this cycle.
- `rob_idx_i` in ROB_IDX_LEN: ROB index of head entry.
- `rob_has_rd_i` in 1: instruction writes an integer destination.
- `rob_rd_idx_i` in REG_IDX_LEN: destination register index.
- `rob_value_i` in XLEN: result value.
- `rob_except_i` in 1: entry raised an exception.
- `rob_except_code_i` in EXCEPT_LEN: exception cause.
- `rf_valid_o` out 1: register file write request.
- `rf_ready_i` in 1: register file accepts write.
- `rf_rd_idx_o` out REG_IDX_LEN: write index.
- `rf_rd_value_o` out XLEN: write value.
- `rs_clr_valid_o` out 1: clear register-status busy entry.
- `rs_clr_rd_idx_o` out REG_IDX_LEN: register to clear.
- `rs_clr_rob_idx_o` out ROB_IDX_LEN: producing ROB tag; status clears only if the tag matches.
- `flush_o` out 1: pipeline flush pulse.
- `except_valid_o` out 1: exception report pulse.
- `except_code_o` out EXCEPT_LEN: reported cause.

## Operation
- FSM states: RUN, FLUSH. Reset state is RUN.
- Output register: `out_valid`, `out_rd`, `out_value`, `out_rob_idx`. `rf_valid_o = out_valid`.
- `drain = out_valid && rf_ready_i`.
- `rob_ready_o = (state==RUN) && (!out_valid || drain)`. This is combinational; `rob_ready_o` does not depend on `rob_valid_i`.
- Accept = `rob_valid_i && rob_ready_o`.
- Accepted entry without exception, with `rob_has_rd_i` set and `rob_rd_idx_i != 0`:
  - loads the output register; `out_valid` is 1 next cycle.
- Accepted entry without exception, with no rd or rd==x0:
  - retires with no RF write.
  - `out_valid` goes to 0 if draining.
- Accepted exception entry:
  - no RF write, no status clear.
  - latches the cause and moves to FLUSH.
- FLUSH, exactly one cycle:
  - `flush_o=1`, `except_valid_o=1`, `except_code_o` = latched cause, `rob_ready_o=0`.
  - returns to RUN.
- An exception is accepted only when the output register is empty or draining in the same cycle, so older writes always complete before the flush.
- `rs_clr_valid_o = drain`, combinational, carrying `out_rd` and `out_rob_idx`.
- Register-file data outputs hold their value while `rf_valid_o && !rf_ready_i`.

## Timing
- Reset values:
  - `out_valid=0`, so `rf_valid_o=0` and `rs_clr_valid_o=0`.
  - `rf_rd_idx_o=0`, `rf_rd_value_o=0`.
  - `flush_o=0`, `except_valid_o=0`, `except_code_o=0`.
  - `rob_ready_o=1` once out of reset.
- Latency: ROB accept at cycle N gives `rf_valid_o` at N+1.
- Throughput: one retire per cycle while `rf_ready_i=1`.
- Simultaneous drain and accept: the register reloads in the same edge with no bubble.
- RF stall (`rf_ready_i=0` with `out_valid=1`): `rob_ready_o=0` and the output register holds.
- Exception accepted at N: `flush_o` and `except_valid_o` high during N+1 only, `rob_ready_o=0` at N+1, accepts resume at N+2.
- Reset asserted mid-operation: pending write discarded and FSM forced to RUN, asynchronously.

## Configuration
- `INT_COMMIT_INSTRET_EN` defined:
  - adds output `instret_o` (out, 64 bits), reset to 0.
  - increments by 1 at each accept of a non-exception entry.
  - wraps modulo 2^64.
- Not defined: no counter and no port.

## Test plan
- Reset, then `rob_valid_i=1`, rd=5, value=0xDEAD, `rf_ready_i=1`:
  - `rf_valid_o=1` next cycle with idx 5 and 0xDEAD.
  - `rs_clr_valid_o=1` with the entry's rob_idx in the same cycle.
- Back-to-back 8 entries (rd 1..8) with `rf_ready_i=1`: 8 consecutive RF writes, no bubbles, `rob_ready_o` stays 1.
- `rf_ready_i=0` for 3 cycles with an entry pending:
  - `rf_valid_o` and data stable, `rob_ready_o=0`, `rs_clr_valid_o=0`.
  - when `rf_ready_i` returns to 1, the write completes and the next entry is accepted in the same cycle.
- Entry with rd=0, and entry with `rob_has_rd_i=0`: no `rf_valid_o`, no clear; instret (if enabled) +2.
- Pending write to rd=3 stalled, then an exception entry with code 0x02:
  - the exception is not accepted until the drain.
  - `flush_o` and `except_valid_o` pulse exactly one cycle with code 0x02.
  - no RF write for the exception entry.
- Assert `rst_n_i` while `out_valid=1` and during FLUSH: all outputs return to reset values immediately, with no RF write afterward.
